// File: rtl/sat_pkg.sv
// Shared SAT-solver types: literals, formulas and the propagation-arbiter state encoding.
// The arbiter watchdog is enabled by defining PROP_ARB_TIMEOUT_EN.
package sat_pkg;

  localparam int NUM_W      = 4;
  localparam int N_CLAUSES  = 4;
  localparam int CLAUSE_LEN = 3;

  typedef logic [NUM_W-1:0] number_literal;

  typedef struct packed {
    number_literal num;
    logic          val;
  } lit;

  typedef struct packed {
    logic [N_CLAUSES-1:0]                clause_en;
    lit   [N_CLAUSES-1:0][CLAUSE_LEN-1:0] clauses;
  } formula;

  localparam lit     zero_lit     = lit'('0);
  localparam formula zero_formula = formula'('0);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RESPOND = 2'd2;
  localparam logic [1:0] ST_DRAIN   = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE    = ST_IDLE,
    ARB_BUSY    = ST_BUSY,
    ARB_RESPOND = ST_RESPOND,
    ARB_DRAIN   = ST_DRAIN
  } arb_state_t;

endpackage

// File: rtl/prop_engine_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning upward from rr_ptr_i, wrapping at N_REQ.
// Purely combinational; used by prop_engine_arbiter (PROP_ARB_TIMEOUT_EN has no effect here).
module prop_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IW    = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    rr_ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // scan priority order and keep only the first hit
  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    cand_s = '0;
    hit_s  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      cand_s         = IW'((int'(rr_ptr_i) + i) % N_REQ);
      hit_s          = req_i[cand_s] & ~any_o;
      pick_o[cand_s] = hit_s;
      idx_o          = hit_s ? cand_s : idx_o;
      any_o          = any_o | hit_s;
    end
  end

endmodule

// File: rtl/prop_engine_arbiter.sv
// Round-robin arbiter sharing one Propagate_literal engine among N_REQ solver front-ends.
// Define PROP_ARB_TIMEOUT_EN to add a BUSY watchdog and the DRAIN state.
module prop_engine_arbiter
  import sat_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  formula           req_formula [N_REQ],
  input  lit               req_lit     [N_REQ],
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] rsp_valid,
  output formula           rsp_formula,
  output logic             rsp_empty_clause,
  output logic             rsp_empty_formula,
  output logic             rsp_timeout,
  output logic             eng_find,
  output formula           eng_in_formula,
  output lit               eng_in_lit,
  input  logic             eng_ended,
  input  logic             eng_empty_clause,
  input  logic             eng_empty_formula,
  input  formula           eng_out_formula,
  output logic             busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
    $error("prop_engine_arbiter: N_REQ must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [1:0]       state_q, state_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  formula           rsp_formula_q, rsp_formula_d;
  logic             rsp_ec_q, rsp_ec_d;
  logic             rsp_ef_q, rsp_ef_d;
  logic             eng_find_q, eng_find_d;
  formula           eng_in_formula_q, eng_in_formula_d;
  lit               eng_in_lit_q, eng_in_lit_d;

  logic [N_REQ-1:0] pick_s;
  logic [IW-1:0]    pick_idx_s;
  logic             pick_any_s;
  logic [IW-1:0]    rr_next_s;

`ifdef PROP_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_to_q, rsp_to_d;
`endif

  prop_rr_pick #(
    .N_REQ (N_REQ),
    .IW    (IW)
  ) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .pick_o   (pick_s),
    .idx_o    (pick_idx_s),
    .any_o    (pick_any_s)
  );

  assign rr_next_s = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + IW'(1);

  // next-state logic; the one-cycle pulses default low every cycle
  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    owner_d          = owner_q;
    gnt_d            = gnt_q;
    rsp_valid_d      = '0;
    rsp_formula_d    = rsp_formula_q;
    rsp_ec_d         = rsp_ec_q;
    rsp_ef_d         = rsp_ef_q;
    eng_find_d       = 1'b0;
    eng_in_formula_d = eng_in_formula_q;
    eng_in_lit_d     = eng_in_lit_q;
`ifdef PROP_ARB_TIMEOUT_EN
    cnt_d            = cnt_q;
    rsp_to_d         = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any_s) begin
          gnt_d            = pick_s;
          owner_d          = pick_idx_s;
          eng_in_formula_d = req_formula[pick_idx_s];
          eng_in_lit_d     = req_lit[pick_idx_s];
          eng_find_d       = 1'b1;
          state_d          = ST_BUSY;
`ifdef PROP_ARB_TIMEOUT_EN
          cnt_d            = '0;
`endif
        end else begin
          gnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (eng_ended) begin
          rsp_valid_d   = gnt_q;
          rsp_formula_d = eng_out_formula;
          rsp_ec_d      = eng_empty_clause;
          rsp_ef_d      = eng_empty_formula;
          state_d       = ST_RESPOND;
`ifdef PROP_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          // abort: hand the operand back unchanged and wait out the engine in DRAIN
          rsp_valid_d   = gnt_q;
          rsp_to_d      = 1'b1;
          rsp_formula_d = eng_in_formula_q;
          rsp_ec_d      = 1'b0;
          rsp_ef_d      = 1'b0;
          state_d       = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
`else
        end else begin
          state_d = ST_BUSY;
`endif
        end
      end
      ST_RESPOND: begin
        gnt_d    = '0;
        rr_ptr_d = rr_next_s;
        state_d  = ST_IDLE;
      end
`ifdef PROP_ARB_TIMEOUT_EN
      ST_DRAIN: begin
        if (eng_ended) begin
          gnt_d    = '0;
          rr_ptr_d = rr_next_s;
          state_d  = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
`endif
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      rr_ptr_q         <= '0;
      owner_q          <= '0;
      gnt_q            <= '0;
      rsp_valid_q      <= '0;
      rsp_formula_q    <= zero_formula;
      rsp_ec_q         <= 1'b0;
      rsp_ef_q         <= 1'b0;
      eng_find_q       <= 1'b0;
      eng_in_formula_q <= zero_formula;
      eng_in_lit_q     <= zero_lit;
`ifdef PROP_ARB_TIMEOUT_EN
      cnt_q            <= '0;
      rsp_to_q         <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      owner_q          <= owner_d;
      gnt_q            <= gnt_d;
      rsp_valid_q      <= rsp_valid_d;
      rsp_formula_q    <= rsp_formula_d;
      rsp_ec_q         <= rsp_ec_d;
      rsp_ef_q         <= rsp_ef_d;
      eng_find_q       <= eng_find_d;
      eng_in_formula_q <= eng_in_formula_d;
      eng_in_lit_q     <= eng_in_lit_d;
`ifdef PROP_ARB_TIMEOUT_EN
      cnt_q            <= cnt_d;
      rsp_to_q         <= rsp_to_d;
`endif
    end
  end

  assign gnt               = gnt_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_formula       = rsp_formula_q;
  assign rsp_empty_clause  = rsp_ec_q;
  assign rsp_empty_formula = rsp_ef_q;
  assign eng_find          = eng_find_q;
  assign eng_in_formula    = eng_in_formula_q;
  assign eng_in_lit        = eng_in_lit_q;
  assign busy              = (state_q != ST_IDLE);
`ifdef PROP_ARB_TIMEOUT_EN
  assign rsp_timeout       = rsp_to_q;
`else
  assign rsp_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_prop_engine_arbiter.sv
// Self-checking bench for prop_engine_arbiter with a behavioural engine and a response scoreboard.
module tb_prop_engine_arbiter;
  import sat_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam formula MASK = formula'(64'h5A5A_0F0F_3C3C_9696);

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] req   = '0;
  formula       req_formula [N];
  lit           req_lit     [N];
  logic [N-1:0] gnt, rsp_valid;
  formula       rsp_formula, eng_in_formula, eng_out_formula;
  logic         rsp_empty_clause, rsp_empty_formula, rsp_timeout, eng_find, busy;
  lit           eng_in_lit;
  logic         eng_ended = 1'b0;
  logic         eng_empty_clause, eng_empty_formula;

  typedef struct {
    int     k;
    formula f;
    logic   ec;
    logic   ef;
    logic   to;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int   eng_lat    = 5;
  int   eng_cnt    = 0;
  bit   eng_silent = 1'b0;
  bit   force_end  = 1'b0;
  logic ec_cfg     = 1'b0;
  logic ef_cfg     = 1'b0;

  prop_engine_arbiter #(
    .N_REQ          (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .req               (req),
    .req_formula       (req_formula),
    .req_lit           (req_lit),
    .gnt               (gnt),
    .rsp_valid         (rsp_valid),
    .rsp_formula       (rsp_formula),
    .rsp_empty_clause  (rsp_empty_clause),
    .rsp_empty_formula (rsp_empty_formula),
    .rsp_timeout       (rsp_timeout),
    .eng_find          (eng_find),
    .eng_in_formula    (eng_in_formula),
    .eng_in_lit        (eng_in_lit),
    .eng_ended         (eng_ended),
    .eng_empty_clause  (eng_empty_clause),
    .eng_empty_formula (eng_empty_formula),
    .eng_out_formula   (eng_out_formula),
    .busy              (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  assign eng_out_formula   = eng_in_formula ^ MASK;
  assign eng_empty_clause  = ec_cfg;
  assign eng_empty_formula = ef_cfg;

  // engine model: ended pulses eng_lat+1 cycles after the cycle in which find is seen
  always begin
    @(posedge clock);
    #1;
    eng_ended = force_end;
    if (reset) begin
      eng_cnt = 0;
    end else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0 && !eng_silent) eng_ended = 1'b1;
      end
      if (eng_find === 1'b1) eng_cnt = eng_lat + 1;
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sb.delete();
  endtask

  task automatic wait_find(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (eng_find === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (rsp_valid !== '0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0000", rsp_valid); end
    n_cmp++; if (busy !== 1'b0 || eng_find !== 1'b0 || rsp_timeout !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags: busy=%b find=%b to=%b want 0 0 0", busy, eng_find, rsp_timeout);
    end
    n_cmp++; if (rsp_formula !== zero_formula || eng_in_formula !== zero_formula || eng_in_lit !== zero_lit) begin
      n_bad++; $display("FAIL reset_data: rsp=%h in=%h lit=%h want zeros", rsp_formula, eng_in_formula, eng_in_lit);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit   ok;
    int   t0;
    exp_t e;
    logic [N-1:0] ev;
    @(negedge clock);
    eng_lat        = 5;
    ec_cfg         = 1'b0;
    ef_cfg         = 1'b1;
    req_formula[2] = formula'({$urandom(), $urandom()});
    req_lit[2]     = '{num: 4'd3, val: 1'b1};
    sb.push_back('{k: 2, f: req_formula[2] ^ MASK, ec: 1'b0, ef: 1'b1, to: 1'b0});
    req[2] = 1'b1;
    t0     = cyc;
    wait_find(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_find: no eng_find within bound"); end
    n_cmp++; if (cyc - t0 !== 1) begin n_bad++; $display("FAIL single_find_lat: got %0d want 1", cyc - t0); end
    n_cmp++; if (gnt !== 4'b0100 || busy !== 1'b1) begin n_bad++; $display("FAIL single_gnt: got %b busy=%b want 0100 1", gnt, busy); end
    n_cmp++; if (eng_in_lit.num !== 4'd3 || eng_in_lit.val !== 1'b1) begin
      n_bad++; $display("FAIL single_lit: got num=%0d val=%b want 3 1", eng_in_lit.num, eng_in_lit.val);
    end
    @(negedge clock);
    n_cmp++; if (eng_find !== 1'b0) begin n_bad++; $display("FAIL single_find_pulse: got %b want 0", eng_find); end
    wait_rsp(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_rsp: no rsp_valid within bound"); end
    n_cmp++; if (cyc - t0 !== 8) begin n_bad++; $display("FAIL single_rsp_lat: got %0d want 8", cyc - t0); end
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++; $display("FAIL single_sb: unexpected response %b", rsp_valid);
    end else begin
      e = sb.pop_front();
      ev = '0; ev[e.k] = 1'b1;
      if (rsp_valid !== ev) begin n_bad++; $display("FAIL single_rsp_valid: got %b want %b", rsp_valid, ev); end
      n_cmp++; if (rsp_formula !== e.f) begin n_bad++; $display("FAIL single_rsp_formula: got %h want %h", rsp_formula, e.f); end
      n_cmp++; if (rsp_empty_clause !== e.ec || rsp_empty_formula !== e.ef || rsp_timeout !== e.to) begin
        n_bad++; $display("FAIL single_rsp_flags: got %b%b%b want %b%b%b", rsp_empty_clause, rsp_empty_formula, rsp_timeout, e.ec, e.ef, e.to);
      end
    end
    req[2] = 1'b0;
    @(negedge clock);
    n_cmp++; if (rsp_valid !== 4'b0000 || gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_after: rsp=%b gnt=%b busy=%b want 0000 0000 0", rsp_valid, gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    int   order [2][4] = '{'{0, 1, 2, 3}, '{2, 3, 0, 1}};
    bit   ok;
    exp_t e;
    logic [N-1:0] ev;
    do_reset();
    eng_lat = 2;
    ec_cfg  = 1'b0;
    ef_cfg  = 1'b0;
    for (int p = 0; p < 2; p++) begin
      if (p == 1) begin
        // one job on requester 1 leaves rr_ptr at 2
        req_formula[1] = formula'({$urandom(), $urandom()});
        req[1] = 1'b1;
        wait_rsp(ok);
        n_cmp++; if (!ok || rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL rr_warmup: got %b want 0010", rsp_valid); end
        req[1] = 1'b0;
        @(negedge clock);
      end
      for (int k = 0; k < N; k++) begin
        req_formula[k] = formula'({$urandom(), $urandom()});
        req_lit[k]     = lit'(5'($urandom_range(0, 31)));
      end
      for (int j = 0; j < N; j++) begin
        sb.push_back('{k: order[p][j], f: req_formula[order[p][j]] ^ MASK, ec: 1'b0, ef: 1'b0, to: 1'b0});
      end
      req = 4'b1111;
      for (int j = 0; j < N; j++) begin
        wait_find(ok);
        ev = '0; ev[sb[0].k] = 1'b1;
        n_cmp++; if (!ok || gnt !== ev) begin n_bad++; $display("FAIL rr_gnt p%0d j%0d: got %b want %b", p, j, gnt, ev); end
        wait_rsp(ok);
        e = sb.pop_front();
        n_cmp++; if (!ok || rsp_valid !== ev) begin n_bad++; $display("FAIL rr_rsp p%0d j%0d: got %b want %b", p, j, rsp_valid, ev); end
        n_cmp++; if (rsp_formula !== e.f) begin n_bad++; $display("FAIL rr_formula p%0d j%0d: got %h want %h", p, j, rsp_formula, e.f); end
        req[e.k] = 1'b0;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_conflict();
    bit   ok;
    exp_t e;
    ec_cfg = 1'b1;
    ef_cfg = 1'b0;
    eng_lat = 3;
    req_formula[3] = formula'({$urandom(), $urandom()});
    sb.push_back('{k: 3, f: req_formula[3] ^ MASK, ec: 1'b1, ef: 1'b0, to: 1'b0});
    req[3] = 1'b1;
    wait_rsp(ok);
    e = sb.pop_front();
    n_cmp++; if (!ok || rsp_valid !== 4'b1000) begin n_bad++; $display("FAIL conflict_rsp: got %b want 1000", rsp_valid); end
    n_cmp++; if (rsp_empty_clause !== e.ec || rsp_empty_formula !== e.ef) begin
      n_bad++; $display("FAIL conflict_flags: got ec=%b ef=%b want %b %b", rsp_empty_clause, rsp_empty_formula, e.ec, e.ef);
    end
    n_cmp++; if (rsp_formula !== e.f) begin n_bad++; $display("FAIL conflict_formula: got %h want %h", rsp_formula, e.f); end
    req[3] = 1'b0;
    ec_cfg = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_withdraw();
    bit ok;
    bit seen;
    req_formula[1] = formula'({$urandom(), $urandom()});
    req[1] = 1'b1;
    wait_find(ok);
    n_cmp++; if (!ok || gnt !== 4'b0010) begin n_bad++; $display("FAIL withdraw_gnt: got %b want 0010", gnt); end
    @(negedge clock);
    req[1] = 1'b0;
    wait_rsp(ok);
    n_cmp++; if (!ok || rsp_valid !== 4'b0010) begin n_bad++; $display("FAIL withdraw_rsp: got %b want 0010", rsp_valid); end
    n_cmp++; if (rsp_formula !== (req_formula[1] ^ MASK)) begin n_bad++; $display("FAIL withdraw_formula: got %h want %h", rsp_formula, req_formula[1] ^ MASK); end
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      if (eng_find !== 1'b0 || gnt !== 4'b0000) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL withdraw_regrant: got a new grant want none"); end
  endtask

  task automatic test_spurious();
    bit seen;
    seen = 1'b0;
    force_end = 1'b1;
    @(negedge clock);
    force_end = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL spurious_end: got response or busy want idle"); end
  endtask

  task automatic test_reset_mid_busy();
    bit ok;
    bit seen;
    eng_lat = 10;
    req_formula[0] = formula'({$urandom(), $urandom()});
    req[0] = 1'b1;
    wait_find(ok);
    n_cmp++; if (!ok || gnt !== 4'b0001) begin n_bad++; $display("FAIL rstmid_gnt: got %b want 0001", gnt); end
    repeat (2) @(negedge clock);
    reset  = 1'b1;
    req[0] = 1'b0;
    @(negedge clock);
    n_cmp++; if (gnt !== 4'b0000 || busy !== 1'b0 || rsp_valid !== 4'b0000) begin
      n_bad++; $display("FAIL rstmid_state: gnt=%b busy=%b rsp=%b want 0000 0 0000", gnt, busy, rsp_valid);
    end
    reset = 1'b0;
    seen  = 1'b0;
    repeat (15) begin
      @(negedge clock);
      if (rsp_valid !== 4'b0000 || busy !== 1'b0) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL rstmid_quiet: got activity after reset want none"); end
    eng_lat = 5;
  endtask

`ifdef PROP_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit   ok;
    bit   seen;
    int   tf;
    exp_t e;
    eng_silent = 1'b1;
    ec_cfg     = 1'b1;
    req_formula[2] = formula'({$urandom(), $urandom()});
    sb.push_back('{k: 2, f: req_formula[2], ec: 1'b0, ef: 1'b0, to: 1'b1});
    req[2] = 1'b1;
    wait_find(ok);
    tf = cyc;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL timeout_find: no eng_find within bound"); end
    wait_rsp(ok);
    e = sb.pop_front();
    n_cmp++; if (!ok || cyc - tf !== TO) begin n_bad++; $display("FAIL timeout_lat: got %0d want %0d", cyc - tf, TO); end
    n_cmp++; if (rsp_valid !== 4'b0100 || rsp_timeout !== e.to) begin n_bad++; $display("FAIL timeout_rsp: got %b to=%b want 0100 1", rsp_valid, rsp_timeout); end
    n_cmp++; if (rsp_formula !== e.f || rsp_empty_clause !== e.ec || rsp_empty_formula !== e.ef) begin
      n_bad++; $display("FAIL timeout_data: got %h %b%b want %h %b%b", rsp_formula, rsp_empty_clause, rsp_empty_formula, e.f, e.ec, e.ef);
    end
    req[2] = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (busy !== 1'b1 || rsp_valid !== 4'b0000) seen = 1'b1;
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL timeout_drain: busy dropped or extra response in drain"); end
    force_end = 1'b1;
    @(negedge clock);
    force_end = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL timeout_drain_end: got busy=%b want 1", busy); end
    @(negedge clock);
    n_cmp++; if (busy !== 1'b0 || gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin
      n_bad++; $display("FAIL timeout_idle: busy=%b gnt=%b rsp=%b want 0 0000 0000", busy, gnt, rsp_valid);
    end
    eng_silent = 1'b0;
    ec_cfg     = 1'b0;
  endtask
`endif

  initial begin
    for (int k = 0; k < N; k++) begin
      req_formula[k] = zero_formula;
      req_lit[k]     = zero_lit;
    end
    test_reset();
    test_single();
    test_round_robin();
    test_conflict();
    test_withdraw();
    test_spurious();
    test_reset_mid_busy();
`ifdef PROP_ARB_TIMEOUT_EN
    test_timeout();
`endif
    n_cmp++; if (sb.size() != 0) begin n_bad++; $display("FAIL sb_leftover: got %0d pending want 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
